tone_arbiter: RTL and testbench

- Shares the single tone generator and its duration timing between two requesters:
  - the melody sequencer (low priority, note-by-note handshake);
  - the key-click beep (high priority, one-shot).
- A beep pre-empts a sounding note, saves the note's remaining duration, and resumes the note after the beep, so every note sounds for exactly its requested number of cycles.
- The block sits between the song FSM and the frequency divider and also implements play/pause.

---
 rtl/tone_arbiter.sv | 153 +++++++++++++++
 tb/tb_tone_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_arbiter.sv
// Shares one tone generator between a low-priority melody sequencer and a
// high-priority key-click beep; pre-empted notes resume with their remaining duration.
module tone_arbiter #(
  parameter int unsigned FREQ_W    = 28,
  parameter int unsigned DUR_W     = 28,
  parameter int unsigned BEEP_FREQ = 47802,
  parameter int unsigned BEEP_DUR  = 2_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mel_req,
  input  logic [FREQ_W-1:0] mel_freq,
  input  logic [DUR_W-1:0]  mel_dur,
  output logic              mel_ack,
  output logic              mel_done,
  input  logic              beep_req,
  input  logic              pause,
  output logic [FREQ_W-1:0] tone_freq,
  output logic              beep_busy,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEL  = 2'd1,
    S_BEEP = 2'd2
  } state_t;

  localparam logic [FREQ_W-1:0] LP_BEEP_FREQ = FREQ_W'(BEEP_FREQ);
  localparam logic [DUR_W-1:0]  LP_BEEP_DUR  = DUR_W'(BEEP_DUR);
  localparam logic [DUR_W-1:0]  LP_ONE       = DUR_W'(1);

  state_t            r_state, w_state;
  logic [DUR_W-1:0]  r_cnt, w_cnt;
  logic [DUR_W-1:0]  r_bcnt, w_bcnt;
  logic [DUR_W-1:0]  r_mel_rem, w_mel_rem;
  logic              r_pre, w_pre;
  logic [FREQ_W-1:0] r_freq_q, w_freq_q;
  logic [FREQ_W-1:0] r_tone, w_tone;
  logic              r_ack, w_ack;
  logic              r_done, w_done;
  logic              r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bcnt    <= '0;
      r_mel_rem <= '0;
      r_pre     <= 1'b0;
      r_freq_q  <= '0;
      r_tone    <= '0;
      r_ack     <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bcnt    <= w_bcnt;
      r_mel_rem <= w_mel_rem;
      r_pre     <= w_pre;
      r_freq_q  <= w_freq_q;
      r_tone    <= w_tone;
      r_ack     <= w_ack;
      r_done    <= w_done;
      r_busy    <= (w_state == S_BEEP);
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_bcnt    = r_bcnt;
    w_mel_rem = r_mel_rem;
    w_pre     = r_pre;
    w_freq_q  = r_freq_q;
    w_ack     = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (beep_req) begin
          w_bcnt  = LP_BEEP_DUR;
          w_pre   = 1'b0;
          w_state = S_BEEP;
        end else if (mel_req && !pause) begin
          w_freq_q = mel_freq;
          w_cnt    = (mel_dur == '0) ? LP_ONE : mel_dur;
          w_ack    = 1'b1;
          w_state  = S_MEL;
        end
      end
      S_MEL: begin
        // A paused note has not consumed the current cycle, so its full count is saved.
        if (pause) begin
          if (beep_req) begin
            w_mel_rem = r_cnt;
            w_pre     = 1'b1;
            w_bcnt    = LP_BEEP_DUR;
            w_state   = S_BEEP;
          end
        end else if (r_cnt == LP_ONE) begin
          w_done = 1'b1;
          if (beep_req) begin
            w_pre   = 1'b0;
            w_bcnt  = LP_BEEP_DUR;
            w_state = S_BEEP;
          end else begin
            w_state = S_IDLE;
          end
        end else if (beep_req) begin
          w_mel_rem = r_cnt - LP_ONE;
          w_pre     = 1'b1;
          w_bcnt    = LP_BEEP_DUR;
          w_state   = S_BEEP;
        end else begin
          w_cnt = r_cnt - LP_ONE;
        end
      end
      S_BEEP: begin
        if (beep_req) begin
          w_bcnt = LP_BEEP_DUR;
        end else if (r_bcnt == LP_ONE) begin
          if (r_pre) begin
            w_cnt   = r_mel_rem;
            w_pre   = 1'b0;
            w_state = S_MEL;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_bcnt = r_bcnt - LP_ONE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_tone = '0;
    if (w_state == S_MEL && !pause) begin
      w_tone = w_freq_q;
    end else if (w_state == S_BEEP) begin
      w_tone = LP_BEEP_FREQ;
    end
  end

  assign mel_ack   = r_ack;
  assign mel_done  = r_done;
  assign tone_freq = r_tone;
  assign beep_busy = r_busy;
  assign state_o   = r_state;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed test-plan scenarios followed by randomized notes/beeps/pauses checked
// against duration-accounting and beep-window rules.
module tb_tone_arbiter;

  localparam int FW = 28;
  localparam int DW = 28;
  localparam int BF = 100;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mel_req;
  logic [FW-1:0] mel_freq;
  logic [DW-1:0] mel_dur;
  logic          mel_ack;
  logic          mel_done;
  logic          beep_req;
  logic          pause;
  logic [FW-1:0] tone_freq;
  logic          beep_busy;
  logic [1:0]    state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int acks    = 0;

  int            btail = 0;
  int            snd, nacks, k, cdur;
  logic          active;
  logic [FW-1:0] cf;
  bit            pen;

  tone_arbiter #(
    .FREQ_W   (FW),
    .DUR_W    (DW),
    .BEEP_FREQ(BF),
    .BEEP_DUR (BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mel_req  (mel_req),
    .mel_freq (mel_freq),
    .mel_dur  (mel_dur),
    .mel_ack  (mel_ack),
    .mel_done (mel_done),
    .beep_req (beep_req),
    .pause    (pause),
    .tone_freq(tone_freq),
    .beep_busy(beep_busy),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mel_ack) acks++;
  endtask

  task automatic hold(input string tag, input int exp, input int n);
    repeat (n) begin
      step();
      chk(tag, 32'(tone_freq), exp);
    end
  endtask

  task automatic rstep();
    logic b, p;
    if (pen && btail == 0 && $urandom_range(0, 5) == 0) pause = !pause;
    beep_req = !pause && ($urandom_range(0, 11) == 0);
    b = beep_req;
    p = pause;
    step();
    if (b) btail = BD;
    else if (btail > 0) btail--;
    chk("r_beep_window", 32'(tone_freq == FW'(BF)), 32'(btail > 0));
    if (p && btail == 0) chk("r_pause_silent", 32'(tone_freq), 0);
    if (mel_ack) begin
      active = 1'b1;
      nacks++;
    end
    if (active && tone_freq == cf) snd++;
    if (mel_done) active = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mel_req = 1'b0; mel_freq = '0; mel_dur = '0;
    beep_req = 1'b0; pause = 1'b0;
    #1;
    chk("rst_tone", 32'(tone_freq), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_busy", 32'(beep_busy), 0);
    chk("rst_ack", 32'(mel_ack), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("idle_state", 32'(state_o), 0);

    // T1: plain note
    mel_freq = 95603; mel_dur = 5; mel_req = 1'b1;
    step();
    chk("t1_ack", 32'(mel_ack), 1);
    chk("t1_tone0", 32'(tone_freq), 95603);
    chk("t1_state", 32'(state_o), 1);
    mel_req = 1'b0;
    hold("t1_tone", 95603, 4);
    step();
    chk("t1_done", 32'(mel_done), 1);
    chk("t1_off", 32'(tone_freq), 0);
    chk("t1_idle", 32'(state_o), 0);
    step();
    chk("t1_done_pulse", 32'(mel_done), 0);

    // T2: beep pre-empts and the note resumes
    acks = 0;
    mel_freq = 12345; mel_dur = 10; mel_req = 1'b1;
    step();
    chk("t2_ack", 32'(mel_ack), 1);
    chk("t2_tone0", 32'(tone_freq), 12345);
    mel_req = 1'b0;
    hold("t2_pre", 12345, 2);
    beep_req = 1'b1;
    step();
    beep_req = 1'b0;
    chk("t2_beep0", 32'(tone_freq), BF);
    chk("t2_busy", 32'(beep_busy), 1);
    chk("t2_state", 32'(state_o), 2);
    hold("t2_beep", BF, 3);
    hold("t2_resume", 12345, 7);
    step();
    chk("t2_done", 32'(mel_done), 1);
    chk("t2_off", 32'(tone_freq), 0);
    chk("t2_acks", 32'(acks), 1);

    // T3: pause freezes the note
    mel_freq = 777; mel_dur = 6; mel_req = 1'b1;
    step();
    chk("t3_ack", 32'(mel_ack), 1);
    mel_req = 1'b0;
    chk("t3_tone0", 32'(tone_freq), 777);
    hold("t3_pre", 777, 1);
    pause = 1'b1;
    hold("t3_pause", 0, 5);
    chk("t3_state", 32'(state_o), 1);
    pause = 1'b0;
    hold("t3_post", 777, 4);
    step();
    chk("t3_done", 32'(mel_done), 1);
    chk("t3_off", 32'(tone_freq), 0);

    // T4: simultaneous requests, beep wins and is retriggered
    mel_freq = 4242; mel_dur = 3; mel_req = 1'b1; beep_req = 1'b1;
    step();
    beep_req = 1'b0;
    chk("t4_beep0", 32'(tone_freq), BF);
    chk("t4_noack", 32'(mel_ack), 0);
    chk("t4_state", 32'(state_o), 2);
    hold("t4_beep", BF, 2);
    beep_req = 1'b1;
    step();
    beep_req = 1'b0;
    chk("t4_retrig", 32'(tone_freq), BF);
    hold("t4_ext", BF, 3);
    step();
    chk("t4_idle_tone", 32'(tone_freq), 0);
    chk("t4_idle_state", 32'(state_o), 0);
    chk("t4_idle_noack", 32'(mel_ack), 0);
    step();
    chk("t4_ack", 32'(mel_ack), 1);
    chk("t4_tone", 32'(tone_freq), 4242);
    mel_req = 1'b0;
    hold("t4_note", 4242, 2);
    step();
    chk("t4_done", 32'(mel_done), 1);

    // T5: beep on the last note cycle does not pre-empt
    mel_freq = 5555; mel_dur = 3; mel_req = 1'b1;
    step();
    chk("t5_ack", 32'(mel_ack), 1);
    mel_req = 1'b0;
    hold("t5_note", 5555, 2);
    beep_req = 1'b1;
    step();
    beep_req = 1'b0;
    chk("t5_done", 32'(mel_done), 1);
    chk("t5_beep0", 32'(tone_freq), BF);
    chk("t5_state", 32'(state_o), 2);
    hold("t5_beep", BF, 3);
    step();
    chk("t5_idle_tone", 32'(tone_freq), 0);
    chk("t5_idle_state", 32'(state_o), 0);
    step();
    chk("t5_noresume", 32'(state_o), 0);

    // T6: reset during a pre-empting beep
    mel_freq = 8888; mel_dur = 10; mel_req = 1'b1;
    step();
    mel_req = 1'b0;
    hold("t6_note", 8888, 1);
    beep_req = 1'b1;
    step();
    beep_req = 1'b0;
    chk("t6_busy", 32'(beep_busy), 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tone", 32'(tone_freq), 0);
    chk("t6_rst_state", 32'(state_o), 0);
    chk("t6_rst_busy", 32'(beep_busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold("t6_noresume", 0, 6);
    chk("t6_idle", 32'(state_o), 0);
    mel_freq = 3333; mel_dur = 2; mel_req = 1'b1;
    step();
    chk("t6_ack", 32'(mel_ack), 1);
    chk("t6_tone", 32'(tone_freq), 3333);
    mel_req = 1'b0;
    hold("t6_note2", 3333, 1);
    step();
    chk("t6_done", 32'(mel_done), 1);

    // T7: zero duration sounds for one cycle
    mel_freq = 2468; mel_dur = 0; mel_req = 1'b1;
    step();
    chk("t7_ack", 32'(mel_ack), 1);
    chk("t7_tone", 32'(tone_freq), 2468);
    mel_req = 1'b0;
    step();
    chk("t7_done", 32'(mel_done), 1);
    chk("t7_off", 32'(tone_freq), 0);

    // Randomized notes with random beeps and pauses
    btail = 0;
    for (int r = 0; r < 40; r++) begin
      pen   = 1'($urandom_range(0, 1));
      pause = 1'b0;
      cf    = FW'($urandom_range(1000, 1_000_000));
      cdur  = int'($urandom_range(0, 12));
      mel_freq = cf; mel_dur = DW'(cdur); mel_req = 1'b1;
      snd = 0; nacks = 0; active = 1'b0;
      k = 0;
      while (!mel_ack && k < 300) begin
        rstep();
        k++;
      end
      chk("r_ack_seen", 32'(mel_ack), 1);
      mel_req = 1'b0;
      k = 0;
      while (!mel_done && k < 500) begin
        rstep();
        k++;
      end
      chk("r_done_seen", 32'(mel_done), 1);
      chk("r_sound_cycles", 32'(snd), (cdur == 0) ? 1 : cdur);
      chk("r_ack_count", 32'(nacks), 1);
    end
    beep_req = 1'b0;
    pause    = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
